// File: rtl/alu_pkg.sv
// Types and elaboration helpers shared by the ALU datapath blocks.
package alu_pkg;

    typedef struct packed {
        logic cout;
        logic overflow;
        logic zero;
        logic negative;
    } adder_flags_t;

    // The stage count has to split the operand into equal, non-empty chunks.
    function automatic bit adder_params_legal(input int unsigned width, input int unsigned stages);
        return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational ripple-carry adder for one pipeline chunk.
module rca_chunk
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [WIDTH:0] carry;

    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = carry[WIDTH];
    assign c_msb = carry[WIDTH-1];

endmodule

// File: rtl/pipelined_carry_adder.sv
// Add/subtract unit whose carry chain is cut into STAGES registered chunks,
// with a valid/ready handshake and flags derived from the final stage.
module pipelined_carry_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             Zero,
    output logic             Negative
);

    localparam int unsigned CHUNK = WIDTH / STAGES;

    if (!adder_params_legal(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_carry_adder: WIDTH must be >= 2 and a multiple of STAGES >= 1");
    end

    logic             en;
    logic [WIDTH-1:0] bx;
    logic             c_msb;
    adder_flags_t     flags;

    assign bx       = Sub ? ~B : B;
    // One enable for every stage: the pipeline only stalls as a whole.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still unconsumed on entry to this stage, own chunk included.
        localparam int unsigned REM = WIDTH - k * CHUNK;
        localparam int unsigned LOW = (k + 1) * CHUNK;

        logic             valid_in;
        logic             carry_in;
        logic [REM-1:0]   a_rem;
        logic [REM-1:0]   b_rem;
        logic [CHUNK-1:0] sum_chunk;
        logic             carry_out;
        logic             c_msb_w;
        logic [LOW-1:0]   sum_d;

        logic             valid_q;
        logic             carry_q;
        logic [LOW-1:0]   sum_q;

        if (k == 0) begin : g_first
            assign valid_in = in_valid;
            assign carry_in = Cin;
            assign a_rem    = A;
            assign b_rem    = bx;
            assign sum_d    = sum_chunk;
        end else begin : g_chain
            assign valid_in = g_stage[k-1].valid_q;
            assign carry_in = g_stage[k-1].carry_q;
            assign a_rem    = g_stage[k-1].g_upper.a_up_q;
            assign b_rem    = g_stage[k-1].g_upper.b_up_q;
            assign sum_d    = {sum_chunk, g_stage[k-1].sum_q};
        end

        rca_chunk #(
            .WIDTH (CHUNK)
        ) u_chunk (
            .a     (a_rem[CHUNK-1:0]),
            .b     (b_rem[CHUNK-1:0]),
            .cin   (carry_in),
            .sum   (sum_chunk),
            .cout  (carry_out),
            .c_msb (c_msb_w)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
            end else if (en) begin
                valid_q <= valid_in;
            end
        end

        // Bubbles leave data untouched, so outputs hold the last real result.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (en && valid_in) begin
                carry_q <= carry_out;
                sum_q   <= sum_d;
            end
        end

        if (k + 1 < STAGES) begin : g_upper
            logic [REM-CHUNK-1:0] a_up_q;
            logic [REM-CHUNK-1:0] b_up_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_up_q <= '0;
                    b_up_q <= '0;
                end else if (en && valid_in) begin
                    a_up_q <= a_rem[REM-1:CHUNK];
                    b_up_q <= b_rem[REM-1:CHUNK];
                end
            end
        end

        if (k + 1 == STAGES) begin : g_last
            logic c_msb_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    c_msb_q <= 1'b0;
                end else if (en && valid_in) begin
                    c_msb_q <= c_msb_w;
                end
            end
        end else begin : g_mid
            logic c_msb_unused;
            assign c_msb_unused = c_msb_w;
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign Sum       = g_stage[STAGES-1].sum_q;
    assign c_msb     = g_stage[STAGES-1].g_last.c_msb_q;

    always_comb begin
        flags          = '0;
        flags.cout     = g_stage[STAGES-1].carry_q;
        flags.overflow = c_msb ^ g_stage[STAGES-1].carry_q;
        flags.zero     = ~|Sum;
        flags.negative = Sum[WIDTH-1];
    end

    assign Cout     = flags.cout;
    assign Overflow = flags.overflow;
    assign Zero     = flags.zero;
    assign Negative = flags.negative;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench: directed corner cases, streaming, backpressure, reset and
// randomised traffic against an arithmetic reference model with a scoreboard.
module tb_pipelined_carry_adder;

    localparam int unsigned W = 32;
    localparam int unsigned S = 4;

    typedef struct {
        logic [31:0] sum;
        logic [3:0]  flg;
        int          issue;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Cin = 1'b0;
    logic        Sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] Sum;
    logic        Cout, Overflow, Zero, Negative;

    logic        v8 = 1'b0, ir8, ov8, co8, of8, z8, n8;
    logic [7:0]  a8 = '0, b8 = '0, s8;
    logic        v16 = 1'b0, ir16, ov16, co16, of16, z16, n16;
    logic [15:0] a16 = '0, b16 = '0, s16;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int pushed = 0;
    int popped = 0;
    exp_t        sb[$];
    logic [31:0] got[$];

    logic [31:0] st_a   [8] = '{32'h00000001, 32'hFFFFFFFF, 32'h12345678, 32'h00000010,
                                32'h80000000, 32'hABCDE123, 32'hDEADBEEF, 32'h7FFFFFFF};
    logic [31:0] st_b   [8] = '{32'h00000001, 32'h00000001, 32'h87654321, 32'h00000020,
                                32'h00000001, 32'h54321DEF, 32'h0BADF00D, 32'h00000001};
    logic        st_cin [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        st_sub [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .Cin(Cin), .Sub(Sub), .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum),
        .Cout(Cout), .Overflow(Overflow), .Zero(Zero), .Negative(Negative)
    );

    pipelined_carry_adder #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .A(a8), .B(b8),
        .Cin(1'b0), .Sub(1'b0), .out_valid(ov8), .out_ready(1'b1), .Sum(s8),
        .Cout(co8), .Overflow(of8), .Zero(z8), .Negative(n8)
    );

    pipelined_carry_adder #(.WIDTH(16), .STAGES(1)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(ir16), .A(a16), .B(b16),
        .Cin(1'b0), .Sub(1'b0), .out_valid(ov16), .out_ready(1'b1), .Sum(s16),
        .Cout(co16), .Overflow(of16), .Zero(z16), .Negative(n16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Reference: plain wide addition; signed overflow from operand/result signs.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub, input int issue);
        exp_t        e;
        logic [31:0] bx;
        logic [32:0] full;
        logic        ovf;
        bx      = sub ? ~b : b;
        full    = {1'b0, a} + {1'b0, bx} + {32'd0, cin};
        ovf     = (a[31] == bx[31]) && (full[31] != a[31]);
        e.sum   = full[31:0];
        e.flg   = {full[32], ovf, full[31:0] == 32'd0, full[31]};
        e.issue = issue;
        return e;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'h00000000;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h7FFFFFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic ordy, input bit lat_chk);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        A         = a;
        B         = b;
        Cin       = cin;
        Sub       = sub;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            chk("output expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                popped++;
                chk("sum", Sum, e.sum);
                chk("flags", {Cout, Overflow, Zero, Negative}, e.flg);
                if (lat_chk) chk("latency", cyc - e.issue, S);
                got.push_back(Sum);
            end
        end
        if (v && in_ready) begin
            sb.push_back(model(a, b, cin, sub, cyc));
            pushed++;
        end
    endtask

    task automatic drain(input bit rnd, input bit lat_chk);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            tick(1'b0, '0, '0, 1'b0, 1'b0, rnd ? ($urandom_range(0, 2) != 0) : 1'b1, lat_chk);
            n++;
        end
        chk("drain complete", popped, pushed);
    endtask

    task automatic single32(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub,
                            input logic [31:0] es, input logic [3:0] ef);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        A         = a;
        B         = b;
        Cin       = cin;
        Sub       = sub;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, lat, S);
        chk({tag, ".sum"}, Sum, es);
        chk({tag, ".flags"}, {Cout, Overflow, Zero, Negative}, ef);
    endtask

    initial begin
        int guard;
        int start;
        int seen;

        // Power-on reset, then outputs must idle at their reset values.
        repeat (2) @(negedge clk);
        chk("reset.out_valid in reset", out_valid, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset.out_valid", out_valid, 1'b0);
            chk("reset.sum", Sum, 32'h0);
            chk("reset.flags", {Cout, Overflow, Zero, Negative}, 4'b0010);
            chk("reset.in_ready", in_ready, 1'b1);
        end
        chk("reset.w8 sum", {ov8, s8, z8}, {1'b0, 8'h00, 1'b1});

        // Directed corner cases with exact latency.
        single32("ovf_pos", 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 4'b0101);
        single32("ovf_neg", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 4'b1110);
        single32("sub_eq", 32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'h00000000, 4'b1010);
        single32("sub_ovf", 32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 4'b1100);

        // Other parameterisations: 8/2 has latency 2, 16/1 has latency 1.
        @(negedge clk);
        v8  = 1'b1;
        a8  = 8'hFF;
        b8  = 8'h01;
        v16 = 1'b1;
        a16 = 16'h7FFF;
        b16 = 16'h0001;
        @(negedge clk);
        v8  = 1'b0;
        v16 = 1'b0;
        chk("w16.valid at 1", ov16, 1'b1);
        chk("w16.sum", s16, 16'h8000);
        chk("w16.flags", {co16, of16, z16, n16}, 4'b0101);
        chk("w8.valid at 1", ov8, 1'b0);
        @(negedge clk);
        chk("w8.valid at 2", ov8, 1'b1);
        chk("w8.sum", s8, 8'h00);
        chk("w8.flags", {co8, of8, z8, n8}, 4'b1010);
        chk("w8.in_ready", {ir8, ir16}, 2'b11);

        // Streaming: 8 back-to-back ops must come out on 8 consecutive cycles.
        drain(1'b0, 1'b0);
        got.delete();
        for (int i = 0; i < 8; i++) tick(1'b1, st_a[i], st_b[i], st_cin[i], st_sub[i], 1'b1, 1'b1);
        drain(1'b0, 1'b1);
        chk("stream.count", got.size(), 8);
        chk("stream.sum2", got[2], 32'h9999999A);
        chk("stream.sum5", got[5], 32'hFFFFFF13);

        // Backpressure: full pipe, 3 stalled cycles with outputs held.
        for (int i = 0; i < 4; i++)
            tick(1'b1, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, rnd_op(), rnd_op(), 1'b0, 1'b0, 1'b0, 1'b0);
            chk("bp.in_ready", in_ready, 1'b0);
            chk("bp.out_valid", out_valid, 1'b1);
            chk("bp.sum held", Sum, sb[0].sum);
            chk("bp.flags held", {Cout, Overflow, Zero, Negative}, sb[0].flg);
        end
        drain(1'b0, 1'b0);

        // Randomised traffic with random backpressure.
        guard = 0;
        start = pushed;
        while (pushed - start < 1000 && guard < 20000) begin
            tick($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 1'b0);
            guard++;
        end
        chk("random.issued", pushed - start, 1000);
        drain(1'b1, 1'b0);

        // Reset with 3 ops in flight: none may reappear.
        for (int i = 0; i < 3; i++) tick(1'b1, rnd_op(), rnd_op(), 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #($urandom_range(1, 8));
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.out_valid in reset", out_valid, 1'b0);
        rst = 1'b0;
        sb.delete();
        popped = pushed;
        #1;
        chk("midrst.out_valid", out_valid, 1'b0);
        chk("midrst.sum", Sum, 32'h0);
        chk("midrst.flags", {Cout, Overflow, Zero, Negative}, 4'b0010);
        chk("midrst.in_ready", in_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (out_valid) seen++;
        end
        chk("midrst.no ghost", seen, 0);

        // Pipeline still works after the mid-run reset.
        single32("post_rst", 32'h12345678, 32'h87654321, 1'b1, 1'b0, 32'h9999999A, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
